// File: rtl/lut_interp_act_pipe_if.sv
// Stream + table-write bundle for lut_interp_act_pipe.
//   in_valid/in_ready/in_data    : z samples into the unit (signed DATA_W)
//   out_valid/out_ready/out_data : activation results a (signed DATA_W)
//   tbl_we/tbl_waddr/tbl_wdata   : runtime table write port
// master modport : the side that feeds z, consumes a and programs the table
// slave modport  : the activation unit itself
interface lut_interp_act_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     tbl_we;
  logic        [ADDR_W-1:0] tbl_waddr;
  logic signed [DATA_W-1:0] tbl_wdata;

  modport master (
    output in_valid, in_data, out_ready, tbl_we, tbl_waddr, tbl_wdata,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, tbl_we, tbl_waddr, tbl_wdata,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_interp_act_pipe.sv
// Pipelined activation unit: programmable table of 2**ADDR_W segment values
// with linear interpolation between neighbouring entries.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous, active-low reset (clears valids, out_data and table)
//   bus  : lut_interp_act_pipe_if.slave (z stream in, a stream out, table write)
// z is split into a signed segment index (upper ADDR_W bits) and an unsigned
// fraction (lower FRAC_W bits). Three register stages: S1 seg/frac, S2 table
// base/next, S3 output. All stages advance together when the output register
// is empty or being consumed.
// Build option: define LUT_INTERP_ROUND_EN for round-half-up interpolation;
// default build truncates (floor).
module lut_interp_act_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic                    clk,
  input logic                    rst,
  lut_interp_act_pipe_if.slave   bus
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  // a = base + ((next-base)*frac >>> FRAC_W); the result always lies between
  // base and next, so only the low DATA_W bits of the sum are needed.
  function automatic logic signed [DATA_W-1:0] interp(
    input logic signed [DATA_W-1:0] base,
    input logic signed [DATA_W-1:0] nxt,
    input logic        [FRAC_W-1:0] frac
  );
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] frac_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] step;
    diff   = {nxt[DATA_W-1], nxt} - {base[DATA_W-1], base};
    diff_x = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    frac_x = {{(PROD_W-FRAC_W){1'b0}}, frac};
    prod   = diff_x * frac_x;
`ifdef LUT_INTERP_ROUND_EN
    prod   = prod + PROD_W'(2 ** (FRAC_W - 1));
`endif
    step   = prod >>> FRAC_W;
    return base + step[DATA_W-1:0];
  endfunction

  logic                     adv;
  logic                     vld_p1, vld_p2, vld_p3;
  logic signed [ADDR_W-1:0] seg_p1;
  logic        [FRAC_W-1:0] frac_p1, frac_p2;
  logic signed [DATA_W-1:0] base_p2, next_p2;
  logic signed [DATA_W-1:0] data_p3;
  logic signed [DATA_W-1:0] tbl [DEPTH];
  logic        [ADDR_W-1:0] row, row_nxt, wrow;

  // Inverting the sign bit turns the signed segment into an ascending row.
  assign row     = {~seg_p1[ADDR_W-1], seg_p1[ADDR_W-2:0]};
  assign row_nxt = row + ADDR_W'(1);
  assign wrow    = {~bus.tbl_waddr[ADDR_W-1], bus.tbl_waddr[ADDR_W-2:0]};

  assign adv          = !vld_p3 || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_p3;
  assign bus.out_data  = data_p3;

  // Table: written on any edge with tbl_we, regardless of stalls. S2 reads
  // with nonblocking semantics, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (bus.tbl_we) begin
      tbl[wrow] <= bus.tbl_wdata;
    end
  end

  // Control and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      data_p3 <= '0;
    end else if (adv) begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      // ---- S2 -> S3: interpolate; bubbles keep the last result ----
      if (vld_p2) data_p3 <= interp(base_p2, next_p2, frac_p2);
    end
  end

  // Datapath registers, no reset needed: qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (adv) begin
      // ---- input -> S1: split z into segment and fraction ----
      if (bus.in_valid) begin
        seg_p1  <= bus.in_data[DATA_W-1:FRAC_W];
        frac_p1 <= bus.in_data[FRAC_W-1:0];
      end
      // ---- S1 -> S2: table lookup; top row has no upper neighbour ----
      if (vld_p1) begin
        base_p2 <= tbl[row];
        next_p2 <= (&row) ? tbl[row] : tbl[row_nxt];
        frac_p2 <= frac_p1;
      end
    end
  end
endmodule

// File: tb/tb_lut_interp_act_pipe.sv
module tb_lut_interp_act_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lut_interp_act_pipe_if #(.DATA_W(8),  .ADDR_W(4)) if8 ();
  lut_interp_act_pipe_if #(.DATA_W(12), .ADDR_W(5)) if12 ();

  lut_interp_act_pipe #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  lut_interp_act_pipe #(.DATA_W(12), .ADDR_W(5)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (if12.slave)
  );

  logic [7:0]         zs [4];
  logic signed [31:0] got [8];
  int                 acc;
  int                 ngot;
  logic               go;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr8(input int seg, input int val);
    if8.tbl_we    = 1'b1;
    if8.tbl_waddr = 4'(seg);
    if8.tbl_wdata = 8'(val);
    tick();
    if8.tbl_we    = 1'b0;
  endtask

  task automatic load_ramp8();
    for (int s = -8; s < 8; s++) wr8(s, s * 16);
  endtask

  task automatic load_ramp12();
    for (int s = -16; s < 16; s++) begin
      if12.tbl_we    = 1'b1;
      if12.tbl_waddr = 5'(s);
      if12.tbl_wdata = 12'(s * 128);
      tick();
    end
    if12.tbl_we = 1'b0;
  endtask

  task automatic get8(input string tag, input logic [7:0] z, input int exp);
    int n;
    if8.out_ready = 1'b1;
    if8.in_valid  = 1'b1;
    if8.in_data   = z;
    tick();
    if8.in_valid  = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, if8.out_valid, 1);
    check(tag, if8.out_data, exp);
  endtask

  task automatic get12(input string tag, input logic [11:0] z, input int exp);
    int n;
    if12.out_ready = 1'b1;
    if12.in_valid  = 1'b1;
    if12.in_data   = z;
    tick();
    if12.in_valid  = 1'b0;
    n = 0;
    while (!if12.out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, if12.out_valid, 1);
    check(tag, if12.out_data, exp);
  endtask

  initial begin
    rst = 1'b0;
    if8.in_valid = 1'b0;  if8.in_data = '0;  if8.out_ready = 1'b1;
    if8.tbl_we = 1'b0;    if8.tbl_waddr = '0; if8.tbl_wdata = '0;
    if12.in_valid = 1'b0; if12.in_data = '0; if12.out_ready = 1'b1;
    if12.tbl_we = 1'b0;   if12.tbl_waddr = '0; if12.tbl_wdata = '0;
    #2;
    check("rst_out_valid", if8.out_valid, 0);
    check("rst_out_data", if8.out_data, 0);
    check("rst_in_ready", if8.in_ready, 1);
    tick();
    rst = 1'b1;
    tick();

    // Ramp, back-to-back stream, result registered on the third edge
    // counting the accept edge.
    load_ramp8();
    zs[0] = 8'h25; zs[1] = 8'h7F; zs[2] = 8'h80; zs[3] = 8'hF8;
    got[0] = 37; got[1] = 112; got[2] = -128; got[3] = -8;
    for (int c = 0; c < 6; c++) begin
      if8.in_valid = (c < 4);
      if8.in_data  = zs[c % 4];
      tick();
      if (c < 2) begin
        check($sformatf("t1_bubble%0d", c), if8.out_valid, 0);
      end else begin
        check($sformatf("t1_vld%0d", c - 2), if8.out_valid, 1);
        check($sformatf("t1_a%0d", c - 2), if8.out_data, got[c - 2]);
      end
    end
    if8.in_valid = 1'b0;
    tick();
    check("t1_drain", if8.out_valid, 0);

    // Small difference: floor vs round-half-up, then a negative slope.
    wr8(1, 3);
`ifdef LUT_INTERP_ROUND_EN
    get8("t2_pos", 8'h05, 1);
`else
    get8("t2_pos", 8'h05, 0);
`endif
    wr8(1, -3);
    get8("t2_neg", 8'h05, -1);
    wr8(1, 16);

    // Backpressure: exactly three accepted while out_ready is low.
    zs[0] = 8'h10; zs[1] = 8'h20; zs[2] = 8'h30; zs[3] = 8'h40;
    if8.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if8.in_valid = (acc < 4);
      if8.in_data  = zs[acc % 4];
      #1;
      go = if8.in_ready && if8.in_valid;
      tick();
      if (go) acc++;
    end
    check("t3_accepted", acc, 3);
    check("t3_in_ready", if8.in_ready, 0);
    check("t3_held_vld", if8.out_valid, 1);
    check("t3_held_a", if8.out_data, 16);
    if8.out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 10; c++) begin
      if8.in_valid = (acc < 4);
      if8.in_data  = zs[acc % 4];
      #1;
      if (if8.out_valid && ngot < 8) begin
        got[ngot] = if8.out_data;
        ngot++;
      end
      go = if8.in_ready && if8.in_valid;
      tick();
      if (go) acc++;
    end
    check("t3_count", ngot, 4);
    check("t3_a0", got[0], 16);
    check("t3_a1", got[1], 32);
    check("t3_a2", got[2], 48);
    check("t3_a3", got[3], 64);

    // Write on the same edge as the lookup is not seen; later ones are.
    if8.in_valid = 1'b1;
    if8.in_data  = 8'h25;
    tick();
    if8.in_valid  = 1'b0;
    if8.tbl_we    = 1'b1;
    if8.tbl_waddr = 4'd2;
    if8.tbl_wdata = 8'd0;
    tick();
    if8.tbl_we = 1'b0;
    tick();
    check("t4_same_edge_vld", if8.out_valid, 1);
    check("t4_same_edge_a", if8.out_data, 37);
    get8("t4_after", 8'h25, 15);

    // Async reset while stalled with a valid result.
    load_ramp8();
    if8.out_ready = 1'b0;
    if8.in_valid  = 1'b1;
    if8.in_data   = 8'h7F;
    tick(); tick(); tick();
    if8.in_valid = 1'b0;
    check("t5_pre_vld", if8.out_valid, 1);
    check("t5_pre_a", if8.out_data, 112);
    #1;
    rst = 1'b0;
    #1;
    check("t5_rst_vld", if8.out_valid, 0);
    check("t5_rst_a", if8.out_data, 0);
    tick();
    rst = 1'b1;
    if8.out_ready = 1'b1;
    tick(); tick(); tick();
    check("t5_discarded", if8.out_valid, 0);
    get8("t5_tbl_row2", 8'h25, 0);
    get8("t5_tbl_top", 8'h7F, 0);

    // Wider configuration.
    load_ramp12();
    get12("t6_0ff", 12'h0FF, 255);
    get12("t6_min", 12'h800, -2048);
    get12("t6_top", 12'h7FF, 1920);
    get12("t6_neg", 12'hFFF, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
